riscv_v_twos_comp_seq: RTL and testbench

Sequencer for the vector two's-complement datapath: accepts a vector negate (vneg) or absolute-value request over an LMUL register group and reads each source register from the VRF. For each register it drives the per-byte complement/merge/osize controls of an internal `riscv_v_twos_comp_sel` instance and returns each result through a valid/ready write-back port. It sits between vector issue and the VRF write-back arbiter.

---
 rtl/riscv_v_twos_comp_seq_if.sv | 54 +++++
 rtl/riscv_v_twos_comp_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_riscv_v_twos_comp_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_twos_comp_seq_if.sv
// Bus bundle for the vector two's-complement sequencer: issue request,
// VRF read port and write-back port. The optional v0 mask input is present
// only when RISCV_V_TWOS_COMP_MASK_EN is defined.
//
// Handshake rules: a request transfers on a rising edge where
// req_valid & req_ready; a write-back transfers on a rising edge where
// wb_valid & wb_ready. Once wb_valid is raised, wb_data/wb_addr/wb_last stay
// stable and wb_valid stays high until that transfer happens. rd_data is not
// handshaked: it must be valid exactly one cycle after rd_en.
interface riscv_v_twos_comp_seq_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_op;
    logic [4:0]            req_osize;
    logic [3:0]            req_lmul;
    logic [4:0]            req_vs2;
    logic [4:0]            req_vd;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
    logic [DATA_WIDTH-1:0] req_mask;
`endif
    logic                  rd_en;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_last;
    logic                  busy;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_osize, req_lmul, req_vs2, req_vd,
        input  rd_data, wb_ready,
        output req_ready, rd_en, rd_addr, wb_valid, wb_addr, wb_data,
        output wb_last, busy
`ifdef RISCV_V_TWOS_COMP_MASK_EN
        , input req_mask
`endif
    );

    // Issue / VRF / write-back arbiter side
    modport master (
        output req_valid, req_op, req_osize, req_lmul, req_vs2, req_vd,
        output rd_data, wb_ready,
        input  req_ready, rd_en, rd_addr, wb_valid, wb_addr, wb_data,
        input  wb_last, busy
`ifdef RISCV_V_TWOS_COMP_MASK_EN
        , output req_mask
`endif
    );
endinterface

// File: rtl/riscv_v_twos_comp_seq.sv
// Vector negate / absolute-value sequencer. Walks an LMUL register group:
// read source register from the VRF, complement elements through the
// byte-sliced riscv_v_twos_comp_sel datapath, return the result on the
// write-back port. Optional feature macro: RISCV_V_TWOS_COMP_MASK_EN
// (v0 mask gates the per-element complement).

// Byte-sliced two's-complement datapath. complement_i marks the LSB byte of
// each element that must be negated; merge_i[j] lets the carry run from byte
// j into byte j+1 (clear on an element's top byte). osize_i == 0 bypasses.
module riscv_v_twos_comp_sel #(
    parameter int DATA_WIDTH = 128
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] complement_i,
    input  logic [DATA_WIDTH/8-1:0] merge_i,
    input  logic [4:0]              osize_i,
    output logic [DATA_WIDTH-1:0]   result_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic       neg;
    logic       cy;
    logic       prev_merge;
    logic [8:0] sum;

    // Invert-and-increment with a carry chain that restarts at element boundaries
    always_comb begin
        result_o   = data_i;
        neg        = 1'b0;
        cy         = 1'b0;
        prev_merge = 1'b0;
        sum        = '0;
        if (osize_i != 5'd0) begin
            for (int j = 0; j < NB; j++) begin
                if (!prev_merge) begin
                    neg = complement_i[j];
                    cy  = complement_i[j];
                end
                sum = {1'b0, data_i[8*j +: 8] ^ {8{neg}}} + {8'd0, neg & cy};
                result_o[8*j +: 8] = sum[7:0];
                cy = sum[8];
                prev_merge = merge_i[j];
            end
        end
    end
endmodule

module riscv_v_twos_comp_seq #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_LMUL   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    riscv_v_twos_comp_seq_if.slave  bus,
    output logic [1:0]              dbg_state_o
);
    localparam int NB = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_EX   = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [3:0] MAX_L = 4'(MAX_LMUL);

    logic [1:0]            state_q, state_d;
    logic [3:0]            k_q, k_d;
    logic                  op_q;
    logic [4:0]            osize_q;
    logic [4:0]            vs2_q;
    logic [4:0]            vd_q;
    logic [3:0]            lmul_q;
    logic [3:0]            lmul_eff;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [4:0]            wb_addr_q;
    logic                  wb_last_q;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
    logic [DATA_WIDTH-1:0] mask_q;
    int                    bit_idx;
`endif

    logic                  accept;
    logic                  last_k;
    logic                  osize_nz;
    int                    lg;
    int                    emask;
    int                    top_idx;
    logic                  act;
    logic [NB-1:0]         cmp;
    logic [NB-1:0]         mrg;
    logic [DATA_WIDTH-1:0] sel_res;

    assign accept   = (state_q == S_IDLE) && bus.req_valid;
    assign last_k   = (k_q == (lmul_q - 4'd1));
    assign osize_nz = (osize_q != 5'd0);

    // Group length: zero means one register, oversize clamps to MAX_LMUL
    always_comb begin
        if (bus.req_lmul == 4'd0)
            lmul_eff = 4'd1;
        else if (bus.req_lmul > MAX_L)
            lmul_eff = MAX_L;
        else
            lmul_eff = bus.req_lmul;
    end

    // Next-state and register-counter logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RD;
                    k_d     = '0;
                end
            end
            S_RD: state_d = S_EX;
            S_EX: state_d = S_WB;
            S_WB: begin
                if (bus.wb_ready) begin
                    if (last_k) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD;
                        k_d     = k_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and register index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 1'b0;
            osize_q <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            lmul_q  <= 4'd1;
        end else if (accept) begin
            op_q    <= bus.req_op;
            osize_q <= bus.req_osize;
            vs2_q   <= bus.req_vs2;
            vd_q    <= bus.req_vd;
            lmul_q  <= lmul_eff;
        end
    end

`ifdef RISCV_V_TWOS_COMP_MASK_EN
    // Capture the v0 mask on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_q <= '0;
        else if (accept)
            mask_q <= bus.req_mask;
    end
`endif

    // Effective element size: lowest set bit of osize, as log2(bytes)
    always_comb begin
        lg = 0;
        if (osize_q[0])
            lg = 0;
        else if (osize_q[1])
            lg = 1;
        else if (osize_q[2])
            lg = 2;
        else if (osize_q[3])
            lg = 3;
        else if (osize_q[4])
            lg = 4;
    end

    // Per-byte merge/complement controls from element geometry and sign bits
    always_comb begin
        cmp     = '0;
        mrg     = '0;
        emask   = (1 << lg) - 1;
        top_idx = 0;
        act     = 1'b0;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
        bit_idx = 0;
`endif
        for (int j = 0; j < NB; j++) begin
            top_idx = j | emask;
            if (top_idx > NB - 1)
                top_idx = NB - 1;
            mrg[j] = osize_nz && ((j & emask) != emask) && (j != NB - 1);
            if (osize_nz && ((j & emask) == 0)) begin
                act = op_q ? bus.rd_data[8*top_idx + 7] : 1'b1;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
                bit_idx = (int'(k_q) * NB + j) >> lg;
                if (bit_idx >= DATA_WIDTH || !mask_q[bit_idx])
                    act = 1'b0;
`endif
                cmp[j] = act;
            end
        end
    end

    riscv_v_twos_comp_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel (
        .data_i       (bus.rd_data),
        .complement_i (cmp),
        .merge_i      (mrg),
        .osize_i      (osize_q),
        .result_o     (sel_res)
    );

    // Register the write-back beat in EX so it is stable throughout WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_last_q <= 1'b0;
        end else if (state_q == S_EX) begin
            wb_data_q <= sel_res;
            wb_addr_q <= vd_q + {1'b0, k_q};
            wb_last_q <= last_k;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rd_en     = (state_q == S_RD);
    assign bus.rd_addr   = (state_q == S_RD) ? (vs2_q + {1'b0, k_q}) : 5'd0;
    assign bus.wb_valid  = (state_q == S_WB);
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_last   = wb_last_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_riscv_v_twos_comp_seq.sv
// Bench for riscv_v_twos_comp_seq: directed vectors plus randomized groups,
// checked by a scoreboard against an arithmetic reference model.
module tb_riscv_v_twos_comp_seq;
    localparam int DW = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    riscv_v_twos_comp_seq_if #(.DATA_WIDTH(DW)) bus();

    riscv_v_twos_comp_seq #(
        .DATA_WIDTH (DW),
        .MAX_LMUL   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] vrf [32];
    logic [DW-1:0] exp_q [$];
    logic [4:0]    exp_wb_addr_q [$];
    logic          exp_last_q [$];
    logic [4:0]    exp_rd_addr_q [$];
    logic          mon_en = 1'b0;
    logic          rnd_ready = 1'b0;
    logic [DW-1:0] all_ones;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_result(input logic op, input logic [4:0] osize,
                                                 input logic [DW-1:0] src, input logic [DW-1:0] mask,
                                                 input int k);
        int w;
        int ne;
        logic [DW-1:0] res, x, r, wm;
        w = 0;
        for (int b = 4; b >= 0; b--)
            if (osize[b]) w = 8 << b;
        if (w == 0) return src;
        wm = '1;
        wm = wm >> (DW - w);
        ne = DW / w;
        res = '0;
        for (int e = 0; e < ne; e++) begin
            x = (src >> (e * w)) & wm;
            r = x;
            if ((op == 1'b0 || x[w-1]) && mask[k * ne + e])
                r = (~x + 1) & wm;
            res = res | (r << (e * w));
        end
        return res;
    endfunction

    function automatic int eff_lmul(input logic [3:0] lmul);
        if (lmul == 0) return 1;
        if (lmul > 8) return 8;
        return int'(lmul);
    endfunction

    // ---------------- VRF model: data one cycle after rd_en ----------------
    always @(posedge clk) begin
        if (!rst_n)
            bus.rd_data <= '0;
        else if (bus.rd_en)
            bus.rd_data <= vrf[bus.rd_addr];
    end

    // ---------------- write-back ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.wb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          stall_pend = 1'b0;
    logic [DW-1:0] st_data;
    logic [4:0]    st_addr;
    logic          st_last;

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (bus.rd_en) begin
                if (exp_rd_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_unexpected: got rd_en=1 addr %0d expected no read", bus.rd_addr);
                end else begin
                    check("rd_addr", DW'(bus.rd_addr), DW'(exp_rd_addr_q.pop_front()));
                end
            end
            if (stall_pend) begin
                check("stall_valid", DW'(bus.wb_valid), DW'(1'b1));
                check("stall_data", bus.wb_data, st_data);
                check("stall_addr", DW'(bus.wb_addr), DW'(st_addr));
                check("stall_last", DW'(bus.wb_last), DW'(st_last));
            end
            if (bus.wb_valid && bus.wb_ready) begin
                stall_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 data %h expected no write-back", bus.wb_data);
                end else begin
                    check("wb_data", bus.wb_data, exp_q.pop_front());
                    check("wb_addr", DW'(bus.wb_addr), DW'(exp_wb_addr_q.pop_front()));
                    check("wb_last", DW'(bus.wb_last), DW'(exp_last_q.pop_front()));
                end
            end else if (bus.wb_valid) begin
                stall_pend = 1'b1;
                st_data = bus.wb_data;
                st_addr = bus.wb_addr;
                st_last = bus.wb_last;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got req_ready=0 after %0d cycles expected 1", guard);
        end
    endtask

    task automatic issue(input logic op, input logic [4:0] osize, input logic [3:0] lmul,
                         input logic [4:0] vs2, input logic [4:0] vd, input logic [DW-1:0] mask);
        int L;
        @(negedge clk);
        if (!bus.req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_not_ready: got req_ready=0 expected 1");
            return;
        end
        L = eff_lmul(lmul);
        for (int k = 0; k < L; k++) begin
            exp_rd_addr_q.push_back(5'(int'(vs2) + k));
            exp_wb_addr_q.push_back(5'(int'(vd) + k));
            exp_last_q.push_back(k == L - 1);
            exp_q.push_back(ref_result(op, osize, vrf[5'(int'(vs2) + k)], mask, k));
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_osize = osize;
        bus.req_lmul  = lmul;
        bus.req_vs2   = vs2;
        bus.req_vd    = vd;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
        bus.req_mask  = mask;
`endif
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, DW'(bus.req_ready), DW'(1'b1));
        check({tag, "_rd_en"},     DW'(bus.rd_en),     DW'(1'b0));
        check({tag, "_wb_valid"},  DW'(bus.wb_valid),  DW'(1'b0));
        check({tag, "_wb_last"},   DW'(bus.wb_last),   DW'(1'b0));
        check({tag, "_busy"},      DW'(bus.busy),      DW'(1'b0));
        check({tag, "_wb_addr"},   DW'(bus.wb_addr),   DW'(5'd0));
        check({tag, "_rd_addr"},   DW'(bus.rd_addr),   DW'(5'd0));
        check({tag, "_wb_data"},   bus.wb_data,        '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] w;
        int guard;
        all_ones = '1;
        for (int i = 0; i < 32; i++) vrf[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_osize = '0;
        bus.req_lmul  = '0;
        bus.req_vs2   = '0;
        bus.req_vd    = '0;
`ifdef RISCV_V_TWOS_COMP_MASK_EN
        bus.req_mask  = '1;
`endif
        bus.wb_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // NEG 8-bit, single register, latency to wb_valid
        bus.wb_ready = 1'b1;
        wait_idle();
        w = rnd_word();
        w[15:0] = 16'h0005;
        vrf[1] = w;
        issue(1'b0, 5'b00001, 4'd1, 5'd1, 5'd2, all_ones);
        @(negedge clk);
        check("lat_t1_rd_en", DW'(bus.rd_en), DW'(1'b1));
        check("lat_t1_wb_valid", DW'(bus.wb_valid), DW'(1'b0));
        @(negedge clk);
        check("lat_t2_rd_en", DW'(bus.rd_en), DW'(1'b0));
        check("lat_t2_wb_valid", DW'(bus.wb_valid), DW'(1'b0));
        @(negedge clk);
        check("lat_t3_wb_valid", DW'(bus.wb_valid), DW'(1'b1));
        check("lat_t3_byte01", DW'(bus.wb_data[15:0]), DW'(16'h00FB));

        // NEG 16-bit element 0x0100, NEG 128-bit of 1
        wait_idle();
        w = rnd_word();
        w[15:0] = 16'h0100;
        vrf[3] = w;
        issue(1'b0, 5'b00010, 4'd1, 5'd3, 5'd4, all_ones);
        wait_idle();
        vrf[5] = 128'd1;
        issue(1'b0, 5'b10000, 4'd1, 5'd5, 5'd6, all_ones);

        // ABS 32-bit including most-negative value
        wait_idle();
        vrf[7] = {32'h7FFFFFFF, 32'h80000000, 32'h00000007, 32'hFFFFFFFF};
        issue(1'b1, 5'b00100, 4'd1, 5'd7, 5'd8, all_ones);
        wait_idle();
        check("abs32_result", bus.wb_data, {32'h7FFFFFFF, 32'h80000000, 32'h00000007, 32'h00000001});

        // Wrap-around addresses with a 4-cycle write-back stall
        wait_idle();
        vrf[31] = rnd_word();
        vrf[0]  = rnd_word();
        bus.wb_ready = 1'b0;
        issue(1'b0, 5'b00001, 4'd2, 5'd31, 5'd30, all_ones);
        guard = 0;
        while (!bus.wb_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("stall_wb_seen", DW'(bus.wb_valid), DW'(1'b1));
        for (int i = 0; i < 4; i++) begin
            check("stall_no_rd", DW'(bus.rd_en), DW'(1'b0));
            @(negedge clk);
        end
        bus.wb_ready = 1'b1;

        // req_valid while busy is ignored
        wait_idle();
        vrf[10] = rnd_word();
        vrf[11] = rnd_word();
        issue(1'b1, 5'b01000, 4'd2, 5'd10, 5'd12, all_ones);
        bus.req_op = 1'b0;
        bus.req_vs2 = 5'd20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            check("busy_req_ready", DW'(bus.req_ready), DW'(1'b0));
            check("busy_flag", DW'(bus.busy), DW'(1'b1));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;

        // Reset during EX of a 4-register group
        wait_idle();
        for (int i = 12; i < 16; i++) vrf[i] = rnd_word();
        issue(1'b0, 5'b00100, 4'd4, 5'd12, 5'd16, all_ones);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_wb_addr_q.delete();
        exp_last_q.delete();
        exp_rd_addr_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_ready", DW'(bus.req_ready), DW'(1'b1));
        vrf[20] = rnd_word();
        issue(1'b1, 5'b00001, 4'd1, 5'd20, 5'd21, all_ones);
        @(negedge clk);
        check("post_rst_rd_en", DW'(bus.rd_en), DW'(1'b1));

`ifdef RISCV_V_TWOS_COMP_MASK_EN
        // Mask gates individual elements
        wait_idle();
        vrf[22] = {16{8'h01}};
        issue(1'b0, 5'b00001, 4'd1, 5'd22, 5'd23, 128'h2);
        wait_idle();
        check("mask_result", bus.wb_data, {{14{8'h01}}, 8'hFF, 8'h01});
`endif

        // Randomized groups with random write-back backpressure
        rnd_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [DW-1:0] m;
            wait_idle();
            for (int i = 0; i < 32; i++) begin
                vrf[i] = rnd_word();
                if ($urandom_range(0, 5) == 0) vrf[i][31:24] = 8'h80;
            end
`ifdef RISCV_V_TWOS_COMP_MASK_EN
            m = rnd_word();
`else
            m = all_ones;
`endif
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), m);
        end

        // Drain
        guard = 0;
        while ((exp_q.size() != 0 || exp_rd_addr_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || exp_rd_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d write-backs and %0d reads outstanding expected 0",
                     exp_q.size(), exp_rd_addr_q.size());
        end
        rnd_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
